// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem requests and presents fetched
// instructions on the IF/ID registers, with a one-entry buffer to absorb downstream stalls.
module pc_fetch_stage #(
    parameter int                 ADDR_W     = 64,
    parameter int                 INSTR_W    = 64,
    parameter int                 STEP       = 8,
    parameter int                 ALIGN_BITS = 3,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               trap_valid,
    input  logic [ADDR_W-1:0]  trap_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               misalign_err
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    typedef enum logic {FETCH, HELD} state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   buf_pc, next_buf_pc;
    logic [INSTR_W-1:0]  buf_instr, next_buf_instr;
    logic [ADDR_W-1:0]   next_pc, next_if_pc, target;
    logic [INSTR_W-1:0]  next_if_instr;
    logic                next_if_valid, next_misalign, redirect;

    assign imem_req  = (state == FETCH);
    assign imem_addr = PC;

    // Trap outranks branch redirect; both share one target mux.
    assign redirect = trap_valid | redirect_valid;
    assign target   = trap_valid ? trap_addr : redirect_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            PC           <= RESET_VEC & ~ALIGN_MASK;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            misalign_err <= 1'b0;
            buf_pc       <= '0;
            buf_instr    <= '0;
        end else begin
            state        <= next_state;
            PC           <= next_pc;
            if_valid     <= next_if_valid;
            if_pc        <= next_if_pc;
            if_instr     <= next_if_instr;
            misalign_err <= next_misalign;
            buf_pc       <= next_buf_pc;
            buf_instr    <= next_buf_instr;
        end
    end

    always_comb begin
        next_state     = state;
        next_pc        = PC;
        next_if_valid  = if_valid;
        next_if_pc     = if_pc;
        next_if_instr  = if_instr;
        next_misalign  = 1'b0;
        next_buf_pc    = buf_pc;
        next_buf_instr = buf_instr;

        if (redirect) begin
            // Redirect wins over stall and drops both the ack data and any buffered entry.
            next_state    = FETCH;
            next_pc       = target & ~ALIGN_MASK;
            next_if_valid = 1'b0;
            next_misalign = |(target & ALIGN_MASK);
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        next_pc = PC + STEP_INC;
                        if (!stall) begin
                            next_if_valid = 1'b1;
                            next_if_pc    = PC;
                            next_if_instr = imem_rdata;
                        end else begin
                            next_buf_pc    = PC;
                            next_buf_instr = imem_rdata;
                            next_state     = HELD;
                        end
                    end else if (!stall) begin
                        next_if_valid = 1'b0;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        next_if_valid = 1'b1;
                        next_if_pc    = buf_pc;
                        next_if_instr = buf_instr;
                        next_state    = FETCH;
                    end
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: expected IF/ID transfers are queued by the stimulus
// and popped by a monitor whenever the stage hands an instruction to a non-stalled consumer.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_addr = '0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_addr = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_rdata;
    logic [63:0] PC;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [63:0] if_instr;
    logic        misalign_err;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] instr;
    } xfer_t;
    xfer_t exp_q[$];

    always #5 clk = ~clk;

    pc_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .trap_addr      (trap_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PC             (PC),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_err   (misalign_err)
    );

    // Instruction memory model: word contents are a fixed function of the address.
    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    assign imem_rdata = mem_data(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_xfer(input logic [63:0] pc);
        xfer_t x;
        x.pc    = pc;
        x.instr = mem_data(pc);
        exp_q.push_back(x);
    endtask

    // Apply one cycle of inputs, then let the edge happen and settle.
    task automatic cyc(input logic ack, input logic stl, input logic rv, input logic [63:0] ra,
                       input logic tv, input logic [63:0] ta);
        imem_ack       = ack;
        stall          = stl;
        redirect_valid = rv;
        redirect_addr  = ra;
        trap_valid     = tv;
        trap_addr      = ta;
        @(posedge clk);
        #1;
    endtask

    // An instruction is consumed whenever it is valid and the consumer is not stalling.
    always @(negedge clk) begin
        if (!rst && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_xfer: got if_pc 0x%0h expected no transfer", if_pc);
            end else begin
                xfer_t x;
                x = exp_q.pop_front();
                chk("xfer_pc", if_pc, x.pc);
                chk("xfer_instr", if_instr, x.instr);
            end
        end
    end

    initial begin
        // Reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_pc", PC, 64'h0);
        chk("rst_if_valid", {63'b0, if_valid}, 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_instr", if_instr, 64'h0);
        chk("rst_misalign", {63'b0, misalign_err}, 64'h0);
        chk("rst_imem_req", {63'b0, imem_req}, 64'h1);

        // Sequential run: 0, 8, 16, 24
        for (int i = 0; i < 4; i++) begin
            expect_xfer(64'(i * 8));
            cyc(1, 0, 0, 0, 0, 0);
            chk("seq_if_pc", if_pc, 64'(i * 8));
            chk("seq_if_valid", {63'b0, if_valid}, 64'h1);
        end
        chk("seq_pc", PC, 64'h20);
        cyc(0, 0, 0, 0, 0, 0);
        chk("bubble_if_valid", {63'b0, if_valid}, 64'h0);
        chk("bubble_pc", PC, 64'h20);

        // Stall while an ack arrives at PC=0x10
        cyc(0, 0, 1, 64'h8, 0, 0);
        chk("redir8_pc", PC, 64'h8);
        expect_xfer(64'h8);
        expect_xfer(64'h10);
        expect_xfer(64'h18);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pre_stall_if_pc", if_pc, 64'h8);
        chk("pre_stall_pc", PC, 64'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            chk("stall_if_pc", if_pc, 64'h8);
            chk("stall_if_valid", {63'b0, if_valid}, 64'h1);
            chk("stall_imem_req", {63'b0, imem_req}, 64'h0);
            chk("stall_pc", PC, 64'h18);
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("release_if_pc", if_pc, 64'h10);
        chk("release_imem_req", {63'b0, imem_req}, 64'h1);
        chk("release_pc", PC, 64'h18);
        cyc(1, 0, 0, 0, 0, 0);
        chk("resume_if_pc", if_pc, 64'h18);
        chk("resume_pc", PC, 64'h20);
        cyc(0, 0, 0, 0, 0, 0);

        // Trap outranks redirect and discards same-cycle ack
        cyc(1, 0, 1, 64'h200, 1, 64'h100);
        chk("prio_pc", PC, 64'h100);
        chk("prio_if_valid", {63'b0, if_valid}, 64'h0);
        chk("prio_misalign", {63'b0, misalign_err}, 64'h0);
        cyc(0, 0, 0, 0, 0, 0);

        // Misaligned target
        cyc(0, 0, 1, 64'h2C, 0, 0);
        chk("mis_pc", PC, 64'h28);
        chk("mis_err", {63'b0, misalign_err}, 64'h1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mis_err_clear", {63'b0, misalign_err}, 64'h0);
        chk("mis_pc_hold", PC, 64'h28);

        // Wrap-around
        cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
        expect_xfer(64'hFFFF_FFFF_FFFF_FFF8);
        cyc(1, 0, 0, 0, 0, 0);
        chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_pc", PC, 64'h0);
        chk("wrap_misalign", {63'b0, misalign_err}, 64'h0);
        cyc(0, 0, 0, 0, 0, 0);

        // Trap while HELD and stalled
        cyc(1, 1, 0, 0, 0, 0);
        chk("held_imem_req", {63'b0, imem_req}, 64'h0);
        cyc(0, 1, 0, 0, 1, 64'h40);
        chk("held_trap_pc", PC, 64'h40);
        chk("held_trap_imem_req", {63'b0, imem_req}, 64'h1);
        chk("held_trap_if_valid", {63'b0, if_valid}, 64'h0);

        // Reset mid-HELD
        cyc(1, 1, 0, 0, 0, 0);
        chk("held2_pc", PC, 64'h48);
        rst = 1'b1;
        cyc(1, 1, 1, 64'h300, 0, 0);
        rst = 1'b0;
        chk("rst_held_pc", PC, 64'h0);
        chk("rst_held_if_valid", {63'b0, if_valid}, 64'h0);
        chk("rst_held_imem_req", {63'b0, imem_req}, 64'h1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_held_no_present", {63'b0, if_valid}, 64'h0);
        cyc(0, 0, 0, 0, 0, 0);

        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
